// File: rtl/tt_sersub_pkg.sv
// Shared types and uio bit map for the bit-serial subtractor tile.
package tt_sersub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sersub_state_e;

  // uio bit indices
  localparam int unsigned LOAD_A = 0;
  localparam int unsigned LOAD_B = 1;
  localparam int unsigned START  = 2;
  localparam int unsigned ZERO   = 3;
  localparam int unsigned BUSY   = 4;
  localparam int unsigned DONE   = 5;
  localparam int unsigned BORROW = 6;
  localparam int unsigned SER    = 7;

  localparam logic [7:0] UIO_OE_BASE = 8'hF0;

endpackage

// File: rtl/tt_half_subtractor.sv
// One-bit half subtractor: diff = a - b, borrow set when b > a.
module tt_half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial unsigned subtractor A - B, LSB first, on the TinyTapeout user interface.
// Optional zero-result flag on uio[3] enabled by SERSUB_ZERO_FLAG_EN.
module tt_um_serial_subtractor
  import tt_sersub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  sersub_state_e      state_q, state_nxt;
  logic               start_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, diff_sh_q;
  logic [WIDTH-1:0]   result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bor_q, borrow_out_q, done_q, busy_q;

  logic               start_edge, idle_or_done, launch, last_bit;
  logic               d1, b1, d, b2;
  logic [WIDTH-1:0]   diff_nxt;
  logic               zero_bit;
  logic               unused_c;

  assign start_edge   = uio_in[START] & ~start_q;
  assign idle_or_done = (state_q != S_RUN);
  assign launch       = idle_or_done & start_edge;
  assign last_bit     = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign diff_nxt     = {d, diff_sh_q[WIDTH-1:1]};

  // Full subtractor: operand bits first, then the running borrow.
  tt_half_subtractor u_hs1 (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .diff   (d1),
    .borrow (b1)
  );

  tt_half_subtractor u_hs2 (
    .a      (d1),
    .b      (bor_q),
    .diff   (d),
    .borrow (b2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_edge) state_nxt = S_RUN;
      S_RUN:          if (last_bit)   state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, serial datapath and completion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
      bor_q        <= 1'b0;
      borrow_out_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      start_q <= uio_in[START];
      if (launch) begin
        // Start beats a same-cycle load; the held operands are used.
        a_sh_q       <= a_q;
        b_sh_q       <= b_q;
        diff_sh_q    <= '0;
        bor_q        <= 1'b0;
        cnt_q        <= '0;
        done_q       <= 1'b0;
        borrow_out_q <= 1'b0;
        busy_q       <= 1'b1;
      end else if (idle_or_done) begin
        if (uio_in[LOAD_A]) a_q <= ui_in[WIDTH-1:0];
        if (uio_in[LOAD_B]) b_q <= ui_in[WIDTH-1:0];
      end else begin
        a_sh_q    <= a_sh_q >> 1;
        b_sh_q    <= b_sh_q >> 1;
        diff_sh_q <= diff_nxt;
        bor_q     <= b1 | b2;
        cnt_q     <= cnt_q + CNT_W'(1);
        if (last_bit) begin
          result_q     <= diff_nxt;
          borrow_out_q <= b1 | b2;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
        end
      end
    end
  end

`ifdef SERSUB_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        zero_q <= 1'b0;
    else if (launch)   zero_q <= 1'b0;
    else if (last_bit) zero_q <= (diff_nxt == '0);
  end

  assign zero_bit = zero_q;
  assign uio_oe   = UIO_OE_BASE | 8'(1 << ZERO);
`else
  assign zero_bit = 1'b0;
  assign uio_oe   = UIO_OE_BASE;
`endif

  assign uo_out = 8'(result_q);

  always_comb begin
    uio_out         = '0;
    uio_out[ZERO]   = zero_bit;
    uio_out[BUSY]   = busy_q;
    uio_out[DONE]   = done_q;
    uio_out[BORROW] = borrow_out_q;
    uio_out[SER]    = (state_q == S_RUN) & d;
  end

  assign unused_c = &{1'b0, ena, uio_in[7:3], ui_in};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Directed self-checking bench for tt_um_serial_subtractor (WIDTH=8).
module tb_tt_um_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_res = 8'h00;

  always #5 clk = ~clk;

  tt_um_serial_subtractor dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); ui_in = a; uio_in = 8'h01;
    @(negedge clk); ui_in = b; uio_in = 8'h02;
    @(negedge clk); uio_in = 8'h00;
  endtask

  // Launch with the given uio/ui bytes, watch all WIDTH bit-cycles, check completion.
  task automatic run_op(input string tag, input logic [7:0] start_uio, input logic [7:0] start_ui,
                        input logic [7:0] exp_res, input logic exp_bor,
                        input logic hold, input logic mid_load);
    logic [7:0] ser;
    int busy_cnt;
    logic early_done, hold_bad;
    ser = 8'h00; busy_cnt = 0; early_done = 1'b0; hold_bad = 1'b0;
    @(negedge clk); ui_in = start_ui; uio_in = start_uio;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser[i] = uio_out[7];
      if (uio_out[4]) busy_cnt++;
      if (uio_out[5]) early_done = 1'b1;
      if (uo_out !== prev_res) hold_bad = 1'b1;
      if (mid_load && i == 3) begin
        ui_in = 8'h77; uio_in = 8'h01;
      end else if (!hold) begin
        uio_in = 8'h00;
      end
      @(negedge clk);
    end
    check({tag, "_serial"}, ser, exp_res);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_no_early_done"}, early_done, 1'b0);
    check({tag, "_uo_held"}, hold_bad, 1'b0);
    check({tag, "_done"}, uio_out[5], 1'b1);
    check({tag, "_busy_off"}, uio_out[4], 1'b0);
    check({tag, "_result"}, uo_out, exp_res);
    check({tag, "_borrow"}, uio_out[6], exp_bor);
`ifdef SERSUB_ZERO_FLAG_EN
    check({tag, "_zero"}, uio_out[3], exp_res == 8'h00);
`else
    check({tag, "_zero"}, uio_out[3], 1'b0);
`endif
    prev_res = exp_res;
  endtask

  initial begin
    int busy_cnt;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #23;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;

    // 1: 0x5A - 0x3C
    load_ab(8'h5A, 8'h3C);
    run_op("t1", 8'h04, 8'h00, 8'h1E, 1'b0, 1'b0, 1'b0);

    // 2: 0x10 - 0x20 wraps with borrow; borrow holds afterwards
    load_ab(8'h10, 8'h20);
    run_op("t2", 8'h04, 8'h00, 8'hF0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("t2_borrow_hold", uio_out[6], 1'b1);

    // 3: zero result and output enables
    load_ab(8'h00, 8'h00);
    run_op("t3", 8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef SERSUB_ZERO_FLAG_EN
    check("t3_uio_oe", uio_oe, 8'hF8);
`else
    check("t3_uio_oe", uio_oe, 8'hF0);
`endif

    // 4: start held high launches a single operation
    load_ab(8'hFF, 8'h01);
    run_op("t4", 8'h04, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (uio_out[4]) busy_cnt++;
    end
    check("t4_no_relaunch", busy_cnt, 0);
    check("t4_done_stays", uio_out[5], 1'b1);
    uio_in = 8'h00;

    // 5: load during RUN ignored; later load in DONE takes effect
    load_ab(8'h80, 8'h01);
    run_op("t5a", 8'h04, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b1);
    load_ab(8'h77, 8'h01);
    run_op("t5b", 8'h04, 8'h00, 8'h76, 1'b0, 1'b0, 1'b0);
    // start edge with load_a in the same cycle: load dropped
    run_op("t5c", 8'h05, 8'h33, 8'h76, 1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset mid-run
    @(negedge clk); uio_in = 8'h04;
    @(negedge clk); uio_in = 8'h00;
    repeat (4) @(negedge clk);
    check("t6_busy_before_rst", uio_out[4], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_uo_out_rst", uo_out, 8'h00);
    check("t6_uio_out_rst", uio_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_idle_uio_out", uio_out, 8'h00);
    prev_res = 8'h00;
    load_ab(8'h09, 8'h03);
    run_op("t6", 8'h04, 8'h00, 8'h06, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
